// File: rtl/cdc_fifo_arb_pkg.sv
// cdc_fifo_arb_pkg: shared state encoding and counter helpers for the CDC FIFO source arbiter
package cdc_fifo_arb_pkg;

    localparam int AbortCntWidth = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        CLR_REQ,
        CLR_WAIT
    } arb_state_e;

    // saturating increment so the abort counter sticks at its maximum
    function automatic logic [AbortCntWidth-1:0] sat_inc(input logic [AbortCntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: picks the first active request at or after a round-robin pointer
module rr_select
    import cdc_fifo_arb_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int IdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  req,
    input  logic [IdWidth-1:0] ptr,
    output logic [NumReq-1:0]  gnt,
    output logic [IdWidth-1:0] idx,
    output logic               vld
);

    localparam logic [IdWidth:0] NumReqW = (IdWidth+1)'(NumReq);

    logic [NumReq-1:0]  rot;
    logic [IdWidth-1:0] off;
    logic [IdWidth:0]   sum;

    // rotate so that the pointer position lands on bit 0
    assign rot = NumReq'({req, req} >> ptr);

    // lowest set bit of the rotated vector is the nearest requester at or after the pointer
    always_comb begin
        off = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (rot[k]) off = IdWidth'(k);
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= NumReqW) ? IdWidth'(sum - NumReqW) : sum[IdWidth-1:0];
    assign vld = |req;
    assign gnt = vld ? (NumReq'(1) << idx) : '0;

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// cdc_fifo_src_arbiter: round-robin burst arbiter feeding a clearable CDC FIFO source port
module cdc_fifo_src_arbiter
    import cdc_fifo_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int IdWidth   = $clog2(NumReq)
) (
    input  logic                             src_clk_i,
    input  logic                             src_rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0]                req_last_i,
    input  logic                             clear_i,
    output logic                             fifo_valid_o,
    input  logic                             fifo_ready_i,
    output logic [DataWidth-1:0]             fifo_data_o,
    output logic [IdWidth-1:0]               fifo_id_o,
    output logic                             fifo_last_o,
    output logic                             fifo_clear_o,
    input  logic                             fifo_clear_pending_i,
    output logic                             busy_o,
    output logic [AbortCntWidth-1:0]         abort_cnt_o
);

    localparam logic [IdWidth:0] NumReqW = (IdWidth+1)'(NumReq);

    arb_state_e         state_q, state_d;
    logic [IdWidth-1:0] ptr_q, ptr_d, idx_q, idx_d, rr_idx, sel_idx;
    logic [NumReq-1:0]  rr_gnt, gnt;
    logic [IdWidth:0]   nxt;
    logic               rr_vld, locked, arb_state, active, go_clr, enter_clr;
    logic               hs, hs_last, open_q, open_d, abort;

    rr_select #(
        .NumReq (NumReq),
        .IdWidth(IdWidth)
    ) u_rr (
        .req(req_valid_i),
        .ptr(ptr_q),
        .gnt(rr_gnt),
        .idx(rr_idx),
        .vld(rr_vld)
    );

    assign locked    = state_q == LOCKED;
    assign arb_state = (state_q == IDLE) | locked;
    // beats only flow out of reset, outside clear states, and while no FIFO clear is in flight
    assign active    = src_rst_ni & arb_state & ~fifo_clear_pending_i;
    assign sel_idx   = locked ? idx_q : rr_idx;
    assign gnt       = active ? (locked ? (NumReq'(1) << idx_q) : rr_gnt) : '0;

    assign fifo_valid_o = active & (locked ? req_valid_i[idx_q] : rr_vld);
    assign req_ready_o  = gnt & {NumReq{fifo_ready_i}};
    assign fifo_data_o  = req_data_i[sel_idx];
    assign fifo_id_o    = sel_idx;
    assign fifo_last_o  = req_last_i[sel_idx];

    assign hs      = fifo_valid_o & fifo_ready_i;
    assign hs_last = hs & fifo_last_o;
    assign nxt     = {1'b0, sel_idx} + 1'b1;

    // a local clear can only be issued when the FIFO is not already clearing
    assign go_clr       = active & clear_i;
    assign fifo_clear_o = go_clr;
    assign enter_clr    = arb_state & (go_clr | fifo_clear_pending_i);
    assign abort        = locked & enter_clr & open_q & ~hs_last;
    assign busy_o       = state_q != IDLE;

    // next-state: grant lock/release, pointer advance and clear sequencing
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        open_d  = open_q;
        case (state_q)
            IDLE, LOCKED: begin
                if (enter_clr) begin
                    state_d = go_clr ? CLR_REQ : CLR_WAIT;
                    ptr_d   = '0;
                    open_d  = 1'b0;
                end else if (hs_last) begin
                    state_d = IDLE;
                    ptr_d   = (nxt >= NumReqW) ? '0 : nxt[IdWidth-1:0];
                    open_d  = 1'b0;
                end else if (fifo_valid_o) begin
                    state_d = LOCKED;
                    idx_d   = sel_idx;
                    open_d  = open_q | hs;
                end
            end
            CLR_REQ:  state_d = fifo_clear_pending_i ? CLR_WAIT : CLR_REQ;
            CLR_WAIT: state_d = fifo_clear_pending_i ? CLR_WAIT : IDLE;
        endcase
    end

    // state, pointer, locked grant, open-burst flag and abort counter
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            open_q      <= 1'b0;
            abort_cnt_o <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            open_q      <= open_d;
            abort_cnt_o <= abort ? sat_inc(abort_cnt_o) : abort_cnt_o;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// tb_cdc_fifo_src_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_cdc_fifo_src_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      valid, ready_o, last;
    logic [N-1:0][DW-1:0] data;
    logic              clear, fvalid, fready, flast, fclear, pending, busy;
    logic [DW-1:0]     fdata;
    logic [IW-1:0]     fid;
    logic [7:0]        abort;

    int total = 0;
    int bad   = 0;

    int m_ptr, m_lid, m_mode, m_abort;
    bit m_lock, m_open;
    bit e_valid, e_clear, e_busy, e_grant;
    int e_id;
    logic [N-1:0] e_ready;
    bit sched[$];

    always #5 clk = ~clk;

    cdc_fifo_src_arbiter #(.NumReq(N), .DataWidth(DW), .IdWidth(IW)) dut (
        .src_clk_i           (clk),
        .src_rst_ni          (rst_n),
        .req_valid_i         (valid),
        .req_ready_o         (ready_o),
        .req_data_i          (data),
        .req_last_i          (last),
        .clear_i             (clear),
        .fifo_valid_o        (fvalid),
        .fifo_ready_i        (fready),
        .fifo_data_o         (fdata),
        .fifo_id_o           (fid),
        .fifo_last_o         (flast),
        .fifo_clear_o        (fclear),
        .fifo_clear_pending_i(pending),
        .busy_o              (busy),
        .abort_cnt_o         (abort)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        valid   = '0;
        last    = '0;
        clear   = 1'b0;
        pending = 1'b0;
        fready  = 1'b1;
        for (int i = 0; i < N; i++) data[i] = $urandom;
        rst_n = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // expected outputs for the current cycle from the arbitration rules
    task automatic model_comb;
        bit run;
        int i;
        run     = (m_mode == 0) && !pending;
        e_valid = 1'b0;
        e_id    = m_lock ? m_lid : 0;
        e_ready = '0;
        if (m_lock) e_valid = valid[m_lid];
        else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!e_valid && valid[i]) begin
                    e_valid = 1'b1;
                    e_id    = i;
                end
            end
        end
        e_grant = run && (m_lock || e_valid);
        e_valid = e_valid && run;
        if (e_grant) e_ready[e_id] = fready;
        e_clear = run && clear;
        e_busy  = m_lock || (m_mode != 0);
    endtask

    // advance the model across one clock edge
    task automatic model_clock;
        bit hs, hl;
        hs = e_valid && fready;
        hl = hs && last[e_id];
        if (m_mode == 0) begin
            if (e_clear || pending) begin
                if (m_lock && m_open && !hl && m_abort < 255) m_abort++;
                m_mode = e_clear ? 1 : 2;
                m_lock = 1'b0;
                m_open = 1'b0;
                m_ptr  = 0;
            end else if (hl) begin
                m_ptr  = (e_id + 1) % N;
                m_lock = 1'b0;
                m_open = 1'b0;
            end else if (e_valid) begin
                m_lock = 1'b1;
                m_lid  = e_id;
                if (hs) m_open = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (pending) m_mode = 2;
        end else if (!pending) m_mode = 0;
    endtask

    task automatic test_reset;
        valid  = '1;
        last   = '1;
        fready = 1'b1;
        clear  = 1'b1;
        pending = 1'b0;
        rst_n  = 1'b0;
        #2;
        total++; if (fvalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", fvalid); end
        total++; if (ready_o !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", ready_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fclear !== 1'b0) begin bad++; $display("FAIL reset_clear got=%b want=0", fclear); end
        tick;
        total++; if (abort !== 8'd0) begin bad++; $display("FAIL reset_abort got=%0d want=0", abort); end
        total++; if (fvalid !== 1'b0) begin bad++; $display("FAIL reset_valid_clk got=%b want=0", fvalid); end
        clear = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [N-1:0] er;
        do_reset;
        valid = '1;
        last  = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            er = '0;
            er[c % N] = 1'b1;
            total++; if (fid !== IW'(c % N)) begin bad++; $display("FAIL rr_id c=%0d got=%0d want=%0d", c, fid, c % N); end
            total++; if (fdata !== data[c % N]) begin bad++; $display("FAIL rr_data c=%0d got=%h want=%h", c, fdata, data[c % N]); end
            total++; if (ready_o !== er) begin bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, ready_o, er); end
            tick;
        end
    endtask

    task automatic test_burst;
        do_reset;
        valid = 4'b0001;
        last  = 4'b0001;
        #1;
        total++; if (fid !== 2'd0) begin bad++; $display("FAIL burst_pre_id got=%0d want=0", fid); end
        tick;
        valid = 4'b0011;
        for (int b = 0; b < 3; b++) begin
            last = {2'b00, (b == 2), 1'b1};
            #1;
            total++; if (fid !== 2'd1 || fvalid !== 1'b1) begin bad++; $display("FAIL burst_id b=%0d got=%0d/%b want=1/1", b, fid, fvalid); end
            total++; if (flast !== (b == 2)) begin bad++; $display("FAIL burst_last b=%0d got=%b want=%b", b, flast, (b == 2)); end
            total++; if (ready_o !== 4'b0010) begin bad++; $display("FAIL burst_ready b=%0d got=%b want=0010", b, ready_o); end
            tick;
        end
        valid = 4'b0101;
        last  = 4'b0101;
        #1;
        total++; if (fid !== 2'd2) begin bad++; $display("FAIL burst_after_id got=%0d want=2", fid); end
        tick;
    endtask

    task automatic test_stall;
        logic [DW-1:0] d2;
        do_reset;
        valid  = 4'b0100;
        last   = 4'b0100;
        fready = 1'b0;
        d2     = data[2];
        for (int c = 0; c < 5; c++) begin
            if (c == 2) valid[0] = 1'b1;
            #1;
            total++; if (fid !== 2'd2 || fvalid !== 1'b1) begin bad++; $display("FAIL stall_id c=%0d got=%0d/%b want=2/1", c, fid, fvalid); end
            total++; if (fdata !== d2) begin bad++; $display("FAIL stall_data c=%0d got=%h want=%h", c, fdata, d2); end
            total++; if (ready_o !== 4'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0000", c, ready_o); end
            tick;
        end
        fready = 1'b1;
        #1;
        total++; if (ready_o !== 4'b0100 || fid !== 2'd2) begin bad++; $display("FAIL stall_release got=%b/%0d want=0100/2", ready_o, fid); end
        tick;
        valid[2] = 1'b0;
        #1;
        total++; if (fid !== 2'd0 || fvalid !== 1'b1) begin bad++; $display("FAIL stall_next got=%0d/%b want=0/1", fid, fvalid); end
        tick;
    endtask

    task automatic test_local_clear;
        do_reset;
        valid = 4'b0100;
        last  = 4'b0100;
        #1;
        total++; if (fid !== 2'd2) begin bad++; $display("FAIL lclr_pre_id got=%0d want=2", fid); end
        tick;
        valid = 4'b0010;
        last  = 4'b0000;
        #1;
        total++; if (fid !== 2'd1 || ready_o !== 4'b0010) begin bad++; $display("FAIL lclr_beat1 got=%0d/%b want=1/0010", fid, ready_o); end
        tick;
        fready = 1'b0;
        clear  = 1'b1;
        #1;
        total++; if (fclear !== 1'b1) begin bad++; $display("FAIL lclr_pulse got=%b want=1", fclear); end
        tick;
        clear = 1'b0;
        #1;
        total++; if (fclear !== 1'b0) begin bad++; $display("FAIL lclr_single got=%b want=0", fclear); end
        total++; if (fvalid !== 1'b0 || ready_o !== 4'b0) begin bad++; $display("FAIL lclr_quiet got=%b/%b want=0/0000", fvalid, ready_o); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL lclr_busy got=%b want=1", busy); end
        total++; if (abort !== 8'd1) begin bad++; $display("FAIL lclr_abort got=%0d want=1", abort); end
        tick;
        pending = 1'b1;
        #1;
        total++; if (fvalid !== 1'b0 || fclear !== 1'b0) begin bad++; $display("FAIL lclr_pend got=%b/%b want=0/0", fvalid, fclear); end
        tick;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL lclr_wait_busy got=%b want=1", busy); end
        tick;
        pending = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || fvalid !== 1'b0) begin bad++; $display("FAIL lclr_fall got=%b/%b want=1/0", busy, fvalid); end
        tick;
        valid  = 4'b1010;
        last   = 4'b1010;
        fready = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || fvalid !== 1'b1 || fid !== 2'd1) begin bad++; $display("FAIL lclr_idle got=%b/%b/%0d want=0/1/1", busy, fvalid, fid); end
        tick;
    endtask

    task automatic test_remote_clear;
        do_reset;
        valid = 4'b0001;
        last  = 4'b0001;
        #1;
        total++; if (fvalid !== 1'b1) begin bad++; $display("FAIL rclr_pre got=%b want=1", fvalid); end
        tick;
        pending = 1'b1;
        for (int c = 0; c < 10; c++) begin
            clear = (c == 5);
            #1;
            total++; if (fvalid !== 1'b0 || ready_o !== 4'b0) begin bad++; $display("FAIL rclr_valid c=%0d got=%b/%b want=0/0000", c, fvalid, ready_o); end
            total++; if (fclear !== 1'b0) begin bad++; $display("FAIL rclr_noclear c=%0d got=%b want=0", c, fclear); end
            if (c > 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL rclr_busy c=%0d got=%b want=1", c, busy); end
            end
            tick;
        end
        clear   = 1'b0;
        pending = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || fvalid !== 1'b0) begin bad++; $display("FAIL rclr_fall got=%b/%b want=1/0", busy, fvalid); end
        tick;
        #1;
        total++; if (busy !== 1'b0 || fvalid !== 1'b1 || abort !== 8'd0) begin bad++; $display("FAIL rclr_idle got=%b/%b/%0d want=0/1/0", busy, fvalid, abort); end
        tick;
    endtask

    task automatic test_abort_sat;
        int want;
        do_reset;
        for (int k = 0; k < 257; k++) begin
            valid  = 4'b0001;
            last   = 4'b0000;
            fready = 1'b1;
            tick;
            fready = 1'b0;
            clear  = 1'b1;
            tick;
            clear   = 1'b0;
            pending = 1'b1;
            tick;
            pending = 1'b0;
            tick;
            if (k == 0 || k >= 253) begin
                want = (k + 1 > 255) ? 255 : k + 1;
                total++; if (abort !== 8'(want)) begin bad++; $display("FAIL abort_cnt k=%0d got=%0d want=%0d", k, abort, want); end
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (abort !== 8'd0) begin bad++; $display("FAIL abort_async_rst got=%0d want=0", abort); end
        tick;
        rst_n  = 1'b1;
        valid  = 4'b0001;
        last   = 4'b0000;
        fready = 1'b1;
        tick;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (abort !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL abort_rst_midburst got=%0d/%b want=0/0", abort, busy); end
        tick;
    endtask

    task automatic test_random;
        int n;
        do_reset;
        m_ptr = 0; m_lid = 0; m_mode = 0; m_abort = 0; m_lock = 1'b0; m_open = 1'b0;
        e_ready = '0;
        sched.delete();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] || e_ready[i]) begin
                    valid[i] = $urandom_range(0, 1);
                    last[i]  = ($urandom_range(0, 2) == 0);
                    data[i]  = $urandom;
                end
            end
            fready  = ($urandom_range(0, 3) != 0);
            pending = (sched.size() > 0) ? sched.pop_front() : 1'b0;
            clear   = (sched.size() == 0) && !pending && ($urandom_range(0, 30) == 0);
            if (sched.size() == 0 && !pending && !clear && $urandom_range(0, 80) == 0) begin
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) sched.push_back(1'b1);
            end
            #1;
            model_comb;
            total++; if (fvalid !== e_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, fvalid, e_valid); end
            total++; if (ready_o !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, ready_o, e_ready); end
            total++; if (fclear !== e_clear) begin bad++; $display("FAIL rnd_clear c=%0d got=%b want=%b", c, fclear, e_clear); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, e_busy); end
            total++; if (abort !== 8'(m_abort)) begin bad++; $display("FAIL rnd_abort c=%0d got=%0d want=%0d", c, abort, m_abort); end
            if (e_valid) begin
                total++; if (fid !== IW'(e_id) || fdata !== data[e_id] || flast !== last[e_id]) begin bad++; $display("FAIL rnd_payload c=%0d got=%0d/%h/%b want=%0d/%h/%b", c, fid, fdata, flast, e_id, data[e_id], last[e_id]); end
            end
            @(posedge clk);
            model_clock;
            if (e_clear) begin
                sched.push_back(1'b0);
                sched.push_back(1'b1);
                sched.push_back(1'b1);
                sched.push_back(1'b1);
            end
            #1;
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_burst;
        test_stall;
        test_local_clear;
        test_remote_clear;
        test_abort_sat;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_src_arbiter.md
CDC_FIFO_SRC_ARBITER -- requirements
Module: cdc_fifo_src_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, number of source requesters sharing one clearable CDC FIFO (legal range 2..16).
REQ-002 The block SHALL have parameter DataWidth, default 32, payload width per beat.
REQ-003 The block SHALL have parameter IdWidth, default $clog2(NumReq), width of the requester tag.
REQ-004 src_clk_i  in  1  source-domain clock.
REQ-005 src_rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  NumReq  per-requester beat valid.
REQ-007 req_ready_o  out  NumReq  per-requester beat ready.
REQ-008 req_data_i  in  NumReq x DataWidth  per-requester payload.
REQ-009 req_last_i  in  NumReq  per-requester last beat of burst.
REQ-010 clear_i  in  1  single-cycle software clear request.
REQ-011 fifo_valid_o / fifo_ready_i  out/in  1 each  handshake to FIFO source port.
REQ-012 fifo_data_o  out  DataWidth  selected payload.
REQ-013 fifo_id_o  out  IdWidth  index of granted requester.
REQ-014 fifo_last_o  out  1  selected last flag.
REQ-015 fifo_clear_o  out  1  single-cycle pulse to FIFO src_clear_i.
REQ-016 fifo_clear_pending_i  in  1  FIFO src_clear_pending_o.
REQ-017 busy_o  out  1  high outside IDLE.
REQ-018 abort_cnt_o  out  8  saturating count of bursts aborted by a clear.

Function
REQ-019 The FSM SHALL have states IDLE, LOCKED, CLR_REQ, CLR_WAIT.
REQ-020 In IDLE, the block SHALL grant combinationally the first valid requester at or after the round-robin pointer; fifo_valid_o = granted req_valid_i; data/id/last SHALL be muxed from the grant.
REQ-021 req_ready_o[i] SHALL equal grant[i] & fifo_ready_i in IDLE/LOCKED, and 0 in CLR_*.
REQ-022 If fifo_valid_o & !fifo_ready_i, or a handshake occurs with last=0, the block SHALL register the grant and enter LOCKED.
REQ-023 In LOCKED, the grant SHALL not change; the block SHALL return to IDLE on the handshake with last=1.
REQ-024 On each handshake with last=1, the pointer SHALL become granted index+1, modulo NumReq.
REQ-025 Requesters SHALL hold valid and data stable until ready; the block SHALL not withdraw fifo_valid_o once asserted except on clear.
REQ-026 clear_i in IDLE/LOCKED, with fifo_clear_pending_i low, SHALL pulse fifo_clear_o for exactly one cycle and enter CLR_REQ the next cycle.
REQ-027 fifo_clear_pending_i rising in IDLE/LOCKED without local clear (remote clear) SHALL enter CLR_WAIT directly, with no fifo_clear_o.
REQ-028 CLR_REQ SHALL wait for fifo_clear_pending_i=1, then go to CLR_WAIT; CLR_WAIT SHALL wait for 0, then go to IDLE.
REQ-029 In CLR_* states, fifo_valid_o SHALL be 0 and clear_i SHALL be ignored; fifo_clear_o SHALL never assert while fifo_clear_pending_i=1.
REQ-030 Leaving LOCKED for a clear while a burst is open (first beat accepted, last not) SHALL increment abort_cnt_o, saturating at 255.
REQ-031 clear_i and a same-cycle handshake SHALL let the handshake complete; the clear still proceeds.
REQ-032 A clear SHALL reset the round-robin pointer to 0.

Reset
REQ-033 While src_rst_ni=0: state IDLE, pointer 0, grant register 0, abort_cnt_o 0, fifo_clear_o 0, busy_o 0; valid/ready outputs 0 since inputs are masked.
REQ-034 Reset mid-burst SHALL not count as an abort.

Structure
REQ-035 A package cdc_fifo_arb_pkg SHALL hold the FSM state enum and AbortCntWidth=8.
REQ-036 Round-robin selection SHALL be one sub-module, rr_select (request vector + pointer -> one-hot grant + index + valid).
REQ-037 The downstream FIFO SHALL be instantiated by the integrator with T = {id, last, data}; it is not inside this block.

Verification
REQ-038 Req0..3 valid, single-beat, ready=1 -> grant order 0,1,2,3,0; fifo_id_o matches the granted requester each cycle.
REQ-039 Req1 bursts 3 beats (last on third), req0 valid throughout -> three req1 beats contiguous, then req2 or req0 per pointer=2.
REQ-040 fifo_ready_i=0 for 5 cycles with req2 valid, req0 rises mid-stall -> id stays 2, data stable; one beat transfers on ready.
REQ-041 clear_i during LOCKED after beat 1 of 4 -> fifo_clear_o one pulse, ready=0, abort_cnt_o=1, IDLE after pending falls.
REQ-042 fifo_clear_pending_i raised externally for 10 cycles -> no fifo_clear_o, valid=0 for those 10 cycles, busy_o=1, then IDLE.
REQ-043 256 aborted bursts -> abort_cnt_o=255; src_rst_ni low -> abort_cnt_o=0 asynchronously.
